// File: rtl/keypad_encoder.sv
// 4x4 active-low matrix keypad scanner with debounce; encodes accepted keys
// onto the feeder keyboard interface (digit strobe/value, option strobe/code).
module keypad_encoder #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] keypad_row,
    output logic [3:0] keypad_col,
    output logic [3:0] keyboard_digit,
    output logic       digit_enable,
    output logic [2:0] keyboard_option,
    output logic       option_enable,
    output logic       key_held
);

    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

    typedef enum logic [2:0] {SCAN, DEBOUNCE, PRESSED, HELD, RELEASE} state_e;
    typedef enum logic [1:0] {KEY_NONE, KEY_DIGIT, KEY_OPTION} key_kind_e;

    typedef struct packed {
        key_kind_e  kind;
        logic [3:0] digit;
        logic [2:0] option;
    } key_code_t;

    state_e        state, next_state;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [CW-1:0] cnt, cnt_next, cnt_inc;
    logic [3:0]    row_meta, row_sync;
    logic [1:0]    col_idx, key_row, low_row, press_row;
    logic          any_low, latch, rotate;
    key_code_t     code;

    // Row/column position to keypad legend.
    function automatic key_code_t decode(input logic [1:0] row, input logic [1:0] col);
        key_code_t k;
        k = '{kind: KEY_NONE, digit: 4'd0, option: 3'd0};
        if (col == 2'd3) begin
            k.kind   = KEY_OPTION;
            k.option = {1'b0, row} + 3'd1;
        end else if (row != 2'd3) begin
            k.kind  = KEY_DIGIT;
            k.digit = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
        end else if (col == 2'd0) begin
            k.kind = KEY_OPTION;
        end else if (col == 2'd1) begin
            k.kind = KEY_DIGIT;
        end
        return k;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= keypad_row;
            row_sync <= row_meta;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)     tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + TW'(1);
    end

    assign tick    = (tick_cnt == TW'(SCAN_DIV - 1));
    assign any_low = ~&row_sync;
    assign low_row = !row_sync[0] ? 2'd0 : !row_sync[1] ? 2'd1 : !row_sync[2] ? 2'd2 : 2'd3;
    assign cnt_inc = cnt + CW'(1);
    assign press_row  = latch ? low_row : key_row;
    assign code       = decode(press_row, col_idx);
    assign keypad_col = ~(4'b0001 << col_idx);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        latch      = 1'b0;
        rotate     = 1'b0;
        case (state)
            SCAN: if (tick) begin
                if (any_low) begin
                    latch      = 1'b1;
                    cnt_next   = CW'(1);
                    next_state = (DEBOUNCE_TICKS == 1) ? PRESSED : DEBOUNCE;
                end else begin
                    rotate = 1'b1;
                end
            end
            DEBOUNCE: if (tick) begin
                if (any_low && low_row == key_row) begin
                    if (cnt_inc == CW'(DEBOUNCE_TICKS)) next_state = PRESSED;
                    else                                cnt_next   = cnt_inc;
                end else begin
                    next_state = SCAN;
                end
            end
            PRESSED: next_state = HELD;
            HELD: if (tick && row_sync[key_row]) begin
                cnt_next   = CW'(1);
                next_state = (DEBOUNCE_TICKS == 1) ? SCAN : RELEASE;
            end
            RELEASE: if (tick) begin
                if (!row_sync[key_row])                  next_state = HELD;
                else if (cnt_inc == CW'(DEBOUNCE_TICKS)) next_state = SCAN;
                else                                     cnt_next   = cnt_inc;
            end
            default: next_state = SCAN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= SCAN;
            cnt     <= '0;
            col_idx <= 2'd0;
            key_row <= 2'd0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            if (rotate) col_idx <= col_idx + 2'd1;
            if (latch)  key_row <= low_row;
        end
    end

    // Strobe and data register together so the value is valid while the strobe is high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            keyboard_digit  <= 4'd0;
            keyboard_option <= 3'd0;
            digit_enable    <= 1'b0;
            option_enable   <= 1'b0;
            key_held        <= 1'b0;
        end else begin
            digit_enable  <= 1'b0;
            option_enable <= 1'b0;
            if (next_state == PRESSED) begin
                if (code.kind == KEY_DIGIT) begin
                    digit_enable   <= 1'b1;
                    keyboard_digit <= code.digit;
                end else if (code.kind == KEY_OPTION) begin
                    option_enable   <= 1'b1;
                    keyboard_option <= code.option;
                end
            end
            if (state == PRESSED)
                key_held <= 1'b1;
            else if ((state == HELD || state == RELEASE) && next_state == SCAN)
                key_held <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder with a behavioural 4x4 switch matrix model.
module tb_keypad_encoder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  keypad_row;
    logic [3:0]  keypad_col;
    logic [3:0]  keyboard_digit;
    logic        digit_enable;
    logic [2:0]  keyboard_option;
    logic        option_enable;
    logic        key_held;
    logic [15:0] pressed = '0;

    int tests_run = 0;
    int fail_cnt  = 0;
    int dig_cnt   = 0;
    int opt_cnt   = 0;
    int both_cnt  = 0;
    int d0, o0;

    keypad_encoder #(.SCAN_DIV(4), .DEBOUNCE_TICKS(3)) dut (
        .clock          (clock),
        .reset          (reset),
        .keypad_row     (keypad_row),
        .keypad_col     (keypad_col),
        .keyboard_digit (keyboard_digit),
        .digit_enable   (digit_enable),
        .keyboard_option(keyboard_option),
        .option_enable  (option_enable),
        .key_held       (key_held)
    );

    always #5 clock = ~clock;

    // A pressed switch pulls its row low only while its column is driven low.
    always_comb begin
        keypad_row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !keypad_col[c]) keypad_row[r] = 1'b0;
    end

    always @(posedge clock) begin
        if (digit_enable)                  dig_cnt  <= dig_cnt + 1;
        if (option_enable)                 opt_cnt  <= opt_cnt + 1;
        if (digit_enable && option_enable) both_cnt <= both_cnt + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_key(input int r, input int c, input logic v);
        pressed[r*4+c] = v;
    endtask

    task automatic test_reset;
        logic [3:0] exp_col;
        reset = 1'b1;
        wait_clk(3);
        tests_run++; if (keypad_col !== 4'b1110) begin fail_cnt++; $display("FAIL reset_col: got %b expected 1110", keypad_col); end
        tests_run++; if (keyboard_digit !== 4'd0) begin fail_cnt++; $display("FAIL reset_digit: got %0d expected 0", keyboard_digit); end
        tests_run++; if (keyboard_option !== 3'd0) begin fail_cnt++; $display("FAIL reset_option: got %0d expected 0", keyboard_option); end
        tests_run++; if ({digit_enable, option_enable, key_held} !== 3'b000) begin fail_cnt++; $display("FAIL reset_flags: got %b expected 000", {digit_enable, option_enable, key_held}); end
        reset = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clock);
            exp_col = ~(4'b0001 << ((n / 4) % 4));
            tests_run++;
            if (keypad_col !== exp_col) begin fail_cnt++; $display("FAIL scan_col clk%0d: got %b expected %b", n, keypad_col, exp_col); end
        end
        tests_run++; if (dig_cnt + opt_cnt !== 0) begin fail_cnt++; $display("FAIL idle_strobes: got %0d expected 0", dig_cnt + opt_cnt); end
    endtask

    task automatic test_digit_press;
        d0 = dig_cnt; o0 = opt_cnt;
        set_key(1, 1, 1'b1);
        wait_clk(40);
        tests_run++; if (dig_cnt !== d0 + 1) begin fail_cnt++; $display("FAIL key5_strobes: got %0d expected %0d", dig_cnt - d0, 1); end
        tests_run++; if (keyboard_digit !== 4'd5) begin fail_cnt++; $display("FAIL key5_digit: got %0d expected 5", keyboard_digit); end
        tests_run++; if (key_held !== 1'b1) begin fail_cnt++; $display("FAIL key5_held: got %b expected 1", key_held); end
        tests_run++; if (opt_cnt !== o0) begin fail_cnt++; $display("FAIL key5_no_option: got %0d expected 0", opt_cnt - o0); end
        set_key(1, 1, 1'b0);
        wait_clk(6);
        tests_run++; if (key_held !== 1'b1) begin fail_cnt++; $display("FAIL key5_release_early: got %b expected 1", key_held); end
        wait_clk(14);
        tests_run++; if (key_held !== 1'b0) begin fail_cnt++; $display("FAIL key5_release: got %b expected 0", key_held); end
        wait_clk(8);
    endtask

    task automatic test_options;
        d0 = dig_cnt; o0 = opt_cnt;
        set_key(0, 3, 1'b1);
        wait_clk(40);
        tests_run++; if (keyboard_option !== 3'b001) begin fail_cnt++; $display("FAIL keyA_option: got %b expected 001", keyboard_option); end
        tests_run++; if (opt_cnt !== o0 + 1) begin fail_cnt++; $display("FAIL keyA_strobes: got %0d expected 1", opt_cnt - o0); end
        set_key(0, 3, 1'b0);
        wait_clk(24);
        set_key(3, 3, 1'b1);
        wait_clk(40);
        tests_run++; if (keyboard_option !== 3'b100) begin fail_cnt++; $display("FAIL keyD_option: got %b expected 100", keyboard_option); end
        tests_run++; if (opt_cnt !== o0 + 2) begin fail_cnt++; $display("FAIL keyD_strobes: got %0d expected 2", opt_cnt - o0); end
        tests_run++; if (keyboard_digit !== 4'd5) begin fail_cnt++; $display("FAIL options_digit_kept: got %0d expected 5", keyboard_digit); end
        tests_run++; if (dig_cnt !== d0) begin fail_cnt++; $display("FAIL options_no_digit: got %0d expected 0", dig_cnt - d0); end
        set_key(3, 3, 1'b0);
        wait_clk(24);
    endtask

    task automatic test_bounce;
        d0 = dig_cnt;
        set_key(2, 0, 1'b1); wait_clk(4);
        set_key(2, 0, 1'b0); wait_clk(4);
        set_key(2, 0, 1'b1); wait_clk(4);
        set_key(2, 0, 1'b0); wait_clk(40);
        tests_run++; if (dig_cnt !== d0) begin fail_cnt++; $display("FAIL bounce_strobes: got %0d expected 0", dig_cnt - d0); end
        tests_run++; if (key_held !== 1'b0) begin fail_cnt++; $display("FAIL bounce_held: got %b expected 0", key_held); end
        set_key(2, 0, 1'b1);
        wait_clk(40);
        tests_run++; if (dig_cnt !== d0 + 1) begin fail_cnt++; $display("FAIL key7_strobes: got %0d expected 1", dig_cnt - d0); end
        tests_run++; if (keyboard_digit !== 4'd7) begin fail_cnt++; $display("FAIL key7_digit: got %0d expected 7", keyboard_digit); end
        set_key(2, 0, 1'b0);
        wait_clk(24);
    endtask

    task automatic test_back_to_back;
        d0 = dig_cnt; o0 = opt_cnt;
        set_key(0, 1, 1'b1);
        wait_clk(40);
        tests_run++; if (keyboard_digit !== 4'd2) begin fail_cnt++; $display("FAIL key2_digit: got %0d expected 2", keyboard_digit); end
        set_key(2, 2, 1'b1);
        wait_clk(30);
        tests_run++; if (dig_cnt !== d0 + 1) begin fail_cnt++; $display("FAIL key9_ignored: got %0d expected 1", dig_cnt - d0); end
        tests_run++; if (keyboard_digit !== 4'd2) begin fail_cnt++; $display("FAIL key9_ignored_digit: got %0d expected 2", keyboard_digit); end
        set_key(0, 1, 1'b0);
        wait_clk(6);
        tests_run++; if (dig_cnt !== d0 + 1) begin fail_cnt++; $display("FAIL key9_early: got %0d expected 1", dig_cnt - d0); end
        wait_clk(60);
        tests_run++; if (dig_cnt !== d0 + 2) begin fail_cnt++; $display("FAIL key9_strobes: got %0d expected 2", dig_cnt - d0); end
        tests_run++; if (keyboard_digit !== 4'd9) begin fail_cnt++; $display("FAIL key9_digit: got %0d expected 9", keyboard_digit); end
        set_key(2, 2, 1'b0);
        wait_clk(24);
        d0 = dig_cnt;
        set_key(3, 2, 1'b1);
        wait_clk(40);
        tests_run++; if (key_held !== 1'b1) begin fail_cnt++; $display("FAIL hash_held: got %b expected 1", key_held); end
        tests_run++; if (dig_cnt + opt_cnt !== d0 + o0) begin fail_cnt++; $display("FAIL hash_no_strobe: got %0d expected 0", dig_cnt + opt_cnt - d0 - o0); end
        set_key(3, 2, 1'b0);
        wait_clk(24);
        tests_run++; if (key_held !== 1'b0) begin fail_cnt++; $display("FAIL hash_release: got %b expected 0", key_held); end
    endtask

    task automatic test_reset_while_held;
        set_key(1, 0, 1'b1);
        wait_clk(40);
        tests_run++; if ({key_held, keyboard_digit} !== {1'b1, 4'd4}) begin fail_cnt++; $display("FAIL key4_before_reset: got %b/%0d expected 1/4", key_held, keyboard_digit); end
        #2 reset = 1'b1;
        #1;
        tests_run++; if (keypad_col !== 4'b1110) begin fail_cnt++; $display("FAIL midreset_col: got %b expected 1110", keypad_col); end
        tests_run++; if ({keyboard_digit, keyboard_option} !== 7'd0) begin fail_cnt++; $display("FAIL midreset_data: got %0d/%0d expected 0/0", keyboard_digit, keyboard_option); end
        tests_run++; if ({digit_enable, option_enable, key_held} !== 3'b000) begin fail_cnt++; $display("FAIL midreset_flags: got %b expected 000", {digit_enable, option_enable, key_held}); end
        wait_clk(2);
        reset = 1'b0;
        d0 = dig_cnt;
        wait_clk(40);
        tests_run++; if (dig_cnt !== d0 + 1) begin fail_cnt++; $display("FAIL key4_redetect: got %0d expected 1", dig_cnt - d0); end
        tests_run++; if ({key_held, keyboard_digit} !== {1'b1, 4'd4}) begin fail_cnt++; $display("FAIL key4_after_reset: got %b/%0d expected 1/4", key_held, keyboard_digit); end
        set_key(1, 0, 1'b0);
        wait_clk(24);
    endtask

    initial begin
        test_reset();
        test_digit_press();
        test_options();
        test_bounce();
        test_back_to_back();
        test_reset_while_held();
        tests_run++; if (both_cnt !== 0) begin fail_cnt++; $display("FAIL strobe_overlap: got %0d expected 0", both_cnt); end
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
